// File: rtl/vga_fb_writer.sv
// CPU-facing pixel writer: synchronized register port, pixel queue, and a
// framebuffer write engine that drains the queue or fills the screen with one colour.
module vga_fb_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_W       = 160,
  parameter int FB_H       = 120
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE,
  input  logic       RW,
  input  logic [1:0] ADDR,
  input  logic [7:0] DATA,
  output logic [7:0] DOUT,
  output logic       DOUT_OE,
  output logic       FB_WE,
  input  logic       FB_READY,
  output logic [7:0] FB_X,
  output logic [6:0] FB_Y,
  output logic [2:0] FB_COLOR
);
  localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam logic [7:0] XMAX = 8'(FB_W - 1);
  localparam logic [6:0] YMAX = 7'(FB_H - 1);
  localparam logic [8:0] XLIM = 9'(FB_W);
  localparam logic [7:0] YLIM = 8'(FB_H);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_DRAIN = 2'd1, S_CLEAR = 2'd2;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic r_ce_s1, r_ce_s2, r_rw_s1, r_rw_s2, r_wr_d, r_oe_d;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic r_auto, r_clr_req, r_ovf;
  logic [2:0] r_clr_col;
  pix_t r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_cnt;
  logic [1:0] r_state;
  logic r_we;
  logic [7:0] r_fx;
  logic [6:0] r_fy;
  logic [2:0] r_fc;

  logic w_wr, w_evt, w_full, w_empty, w_push, w_pop, w_acc, w_free, w_clr_go;
  logic [AW:0] w_avail;
  pix_t w_head;

  assign w_wr    = !r_ce_s2 && !r_rw_s2;
  assign w_evt   = w_wr && !r_wr_d;
  assign DOUT_OE = !r_ce_s2 && r_rw_s2;
  assign w_full  = (r_cnt == FULL_CNT);
  assign w_empty = (r_cnt == '0);
  assign w_push  = w_evt && (ADDR == 2'd2) && !w_full;
  assign w_acc   = r_we && FB_READY;
  assign w_pop   = w_acc && (r_state == S_DRAIN);
  // Output stage can take a new request when idle or when the current one is accepted.
  assign w_free  = !r_we || FB_READY;
  assign w_avail = r_cnt - (AW+1)'(w_pop);
  assign w_head  = r_mem[r_rd + AW'(w_pop)];
  assign w_clr_go = r_clr_req && ((r_state == S_IDLE) || (r_state == S_DRAIN && w_free));

  assign DOUT     = {4'b0, r_ovf, (r_state == S_CLEAR), w_empty, w_full};
  assign FB_WE    = r_we;
  assign FB_X     = r_fx;
  assign FB_Y     = r_fy;
  assign FB_COLOR = r_fc;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      {r_ce_s1, r_ce_s2, r_rw_s1, r_rw_s2, r_wr_d, r_oe_d} <= 6'b111100;
    end else begin
      r_ce_s1 <= CE;
      r_ce_s2 <= r_ce_s1;
      r_rw_s1 <= RW;
      r_rw_s2 <= r_rw_s1;
      r_wr_d  <= w_wr;
      r_oe_d  <= DOUT_OE;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_x <= '0; r_y <= '0; r_auto <= 1'b0; r_clr_col <= '0;
      r_clr_req <= 1'b0; r_ovf <= 1'b0;
    end else begin
      if (r_oe_d && !DOUT_OE) r_ovf <= 1'b0;
      if (w_clr_go) r_clr_req <= 1'b0;
      if (w_evt) begin
        case (ADDR)
          2'd0: r_x <= ({1'b0, DATA} >= XLIM) ? XMAX : DATA;
          2'd1: r_y <= (DATA >= YLIM) ? YMAX : DATA[6:0];
          2'd2: begin
            if (w_full) r_ovf <= 1'b1;
            else if (r_auto) begin
              if (r_x == XMAX) begin
                r_x <= '0;
                r_y <= (r_y == YMAX) ? '0 : r_y + 7'd1;
              end else r_x <= r_x + 8'd1;
            end
          end
          default: begin
            r_auto    <= DATA[0];
            r_clr_col <= DATA[5:3];
            if (DATA[1] && r_state != S_CLEAR) r_clr_req <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= '{x: r_x, y: r_y, c: DATA[2:0]};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr <= '0; r_rd <= '0; r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_push);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE; r_we <= 1'b0; r_fx <= '0; r_fy <= '0; r_fc <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DRAIN: begin
          if (w_clr_go) begin
            r_state <= S_CLEAR; r_we <= 1'b1;
            r_fx <= '0; r_fy <= '0; r_fc <= r_clr_col;
          end else if (w_free) begin
            if (w_avail != '0) begin
              r_state <= S_DRAIN; r_we <= 1'b1;
              {r_fx, r_fy, r_fc} <= w_head;
            end else begin
              r_we <= 1'b0;
              if (!w_push) r_state <= S_IDLE;
            end
          end
        end
        S_CLEAR: begin
          if (w_acc) begin
            if (r_fx == XMAX && r_fy == YMAX) begin
              r_we    <= 1'b0;
              r_state <= w_empty ? S_IDLE : S_DRAIN;
            end else if (r_fx == XMAX) begin
              r_fx <= '0; r_fy <= r_fy + 7'd1;
            end else r_fx <= r_fx + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE; r_we <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed bench for vga_fb_writer: CPU register writes/reads, queue draining,
// overflow, back-pressure hold, full-screen clear and reset during clear.
module tb_vga_fb_writer;
  logic CLK = 1'b0, RESET_N = 1'b0, CE = 1'b1, RW = 1'b1, FB_READY = 1'b0;
  logic [1:0] ADDR = '0;
  logic [7:0] DATA = '0;
  logic [7:0] DOUT;
  logic DOUT_OE, FB_WE;
  logic [7:0] FB_X;
  logic [6:0] FB_Y;
  logic [2:0] FB_COLOR;

  vga_fb_writer #(.FIFO_DEPTH(4), .FB_W(160), .FB_H(120)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .RW(RW), .ADDR(ADDR), .DATA(DATA),
    .DOUT(DOUT), .DOUT_OE(DOUT_OE), .FB_WE(FB_WE), .FB_READY(FB_READY),
    .FB_X(FB_X), .FB_Y(FB_Y), .FB_COLOR(FB_COLOR));

  always #5 CLK = ~CLK;

  int n_vec = 0, n_err = 0, cyc = 0, t_ce = 0, t_acc = 0;
  int clr_acc = 0, bad_ord = 0, bad_busy = 0;
  bit clr_mode = 1'b0, p_stall = 1'b0;
  logic [7:0] ex = '0;
  logic [6:0] ey = '0;
  logic [14:0] last_clr = '0;
  logic [17:0] p_xyc = '0;
  logic [17:0] log_q[$];
  logic [7:0] st;

  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] pix(input int x, input int y, input int c);
    return {8'(x), 7'(y), 3'(c)};
  endfunction

  task automatic expect_pix(input string tag, input logic [17:0] exp);
    if (log_q.size() == 0) chk(tag, 32'hFFFFFFFF, {14'b0, exp});
    else chk(tag, {14'b0, log_q.pop_front()}, {14'b0, exp});
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge CLK); #1;
    CE = 1'b0; RW = 1'b0; ADDR = a; DATA = d; t_ce = cyc;
    repeat (4) @(posedge CLK); #1;
    CE = 1'b1; RW = 1'b1;
    repeat (3) @(posedge CLK); #1;
  endtask

  task automatic cpu_rd(output logic [7:0] d);
    @(posedge CLK); #1;
    CE = 1'b0; RW = 1'b1;
    repeat (3) @(posedge CLK); #1;
    chk("dout_oe", {31'b0, DOUT_OE}, 32'd1);
    d = DOUT;
    CE = 1'b1;
    repeat (3) @(posedge CLK); #1;
  endtask

  // Accepted-write monitor; clear-mode writes are checked against the raster order.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (p_stall) begin
        chk("hold_we", {31'b0, FB_WE}, 32'd1);
        chk("hold_xyc", {14'b0, FB_X, FB_Y, FB_COLOR}, {14'b0, p_xyc});
      end
      if (FB_WE && FB_READY) begin
        if (clr_mode && clr_acc < 19200) begin
          if ({FB_X, FB_Y, FB_COLOR} !== {ex, ey, 3'b010}) bad_ord++;
          if (DOUT[2] !== 1'b1) bad_busy++;
          last_clr = {FB_X, FB_Y};
          if (ex == 8'd159) begin ex = '0; ey = ey + 7'd1; end
          else ex = ex + 8'd1;
          clr_acc++;
        end else begin
          log_q.push_back({FB_X, FB_Y, FB_COLOR});
          t_acc = cyc;
        end
      end
      p_stall = FB_WE && !FB_READY;
      p_xyc = {FB_X, FB_Y, FB_COLOR};
    end else p_stall = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK); #1;
    chk("rst_dout", {24'b0, DOUT}, 32'h02);
    chk("rst_oe", {31'b0, DOUT_OE}, 32'd0);
    chk("rst_we", {31'b0, FB_WE}, 32'd0);
    chk("rst_xyc", {14'b0, FB_X, FB_Y, FB_COLOR}, 32'd0);
    RESET_N = 1'b1;
    repeat (2) @(posedge CLK); #1;

    // single pixel with auto-increment, latency from CE fall
    FB_READY = 1'b1;
    cpu_wr(2'd3, 8'h01); cpu_wr(2'd0, 8'd5); cpu_wr(2'd1, 8'd7);
    log_q.delete();
    cpu_wr(2'd2, 8'h05);
    chk("lat_le6", {31'b0, (t_acc - t_ce) <= 6}, 32'd1);
    expect_pix("px_5_7", pix(5, 7, 5));
    cpu_wr(2'd2, 8'h01);
    expect_pix("px_6_7", pix(6, 7, 1));

    // cursor saturation at the exact limits
    cpu_wr(2'd3, 8'h00); cpu_wr(2'd0, 8'd160); cpu_wr(2'd1, 8'd120);
    cpu_wr(2'd2, 8'h02);
    expect_pix("sat_xy", pix(159, 119, 2));

    // auto-increment wrap at the last pixel
    cpu_wr(2'd3, 8'h01); cpu_wr(2'd0, 8'd159); cpu_wr(2'd1, 8'd119);
    cpu_wr(2'd2, 8'h03); cpu_wr(2'd2, 8'h04);
    expect_pix("wrap_a", pix(159, 119, 3));
    expect_pix("wrap_b", pix(0, 0, 4));

    // overflow with the scanner busy
    FB_READY = 1'b0;
    cpu_wr(2'd0, 8'd10); cpu_wr(2'd1, 8'd3);
    for (int c = 1; c <= 5; c++) cpu_wr(2'd2, 8'(c));
    cpu_rd(st);
    chk("ovf_status", {24'b0, st}, 32'h09);
    chk("ovf_none_out", log_q.size(), 32'd0);
    FB_READY = 1'b1;
    repeat (10) @(posedge CLK); #1;
    chk("ovf_cnt", log_q.size(), 32'd4);
    for (int c = 1; c <= 4; c++) expect_pix("ovf_ord", pix(9 + c, 3, c));
    cpu_rd(st);
    chk("ovf_clr", {24'b0, st}, 32'h02);
    cpu_wr(2'd2, 8'h06);
    expect_pix("ovf_cursor", pix(14, 3, 6));

    // toggling FB_READY while draining
    FB_READY = 1'b0;
    cpu_wr(2'd0, 8'd20); cpu_wr(2'd1, 8'd30);
    for (int c = 1; c <= 3; c++) cpu_wr(2'd2, 8'(c));
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      FB_READY = ~FB_READY;
    end
    FB_READY = 1'b1;
    repeat (5) @(posedge CLK); #1;
    chk("tog_cnt", log_q.size(), 32'd3);
    for (int c = 1; c <= 3; c++) expect_pix("tog_ord", pix(19 + c, 30, c));

    // full clear with a pixel queued and a repeated clear command mid-way
    cpu_wr(2'd3, 8'h00); cpu_wr(2'd0, 8'd7); cpu_wr(2'd1, 8'd9);
    log_q.delete();
    clr_acc = 0; bad_ord = 0; bad_busy = 0; ex = '0; ey = '0; clr_mode = 1'b1;
    cpu_wr(2'd3, 8'h12);
    chk("clr_busy", {31'b0, DOUT[2]}, 32'd1);
    cpu_wr(2'd2, 8'h06);
    cpu_wr(2'd3, 8'h12);
    for (int i = 0; i < 25000; i++) begin
      @(negedge CLK);
      if (!DOUT[2]) break;
    end
    chk("clr_done", {31'b0, DOUT[2]}, 32'd0);
    repeat (30) @(posedge CLK); #1;
    chk("clr_cnt", clr_acc, 32'd19200);
    chk("clr_order", bad_ord, 32'd0);
    chk("clr_busy_all", bad_busy, 32'd0);
    chk("clr_last", {17'b0, last_clr}, {17'b0, 8'd159, 7'd119});
    chk("clr_queued_cnt", log_q.size(), 32'd1);
    expect_pix("clr_queued", pix(7, 9, 6));

    // reset during a clear abandons it
    clr_acc = 0; ex = '0; ey = '0;
    cpu_wr(2'd3, 8'h12);
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK); #1;
      if (clr_acc >= 1000) break;
    end
    chk("rst_at_1000", clr_acc, 32'd1000);
    RESET_N = 1'b0;
    #1;
    chk("rst_we_now", {31'b0, FB_WE}, 32'd0);
    chk("rst_dout_now", {24'b0, DOUT}, 32'h02);
    repeat (2) @(posedge CLK); #1;
    RESET_N = 1'b1;
    clr_mode = 1'b0;
    log_q.delete();
    repeat (20) @(posedge CLK); #1;
    chk("post_rst_we", {31'b0, FB_WE}, 32'd0);
    chk("post_rst_none", log_q.size(), 32'd0);
    cpu_rd(st);
    chk("post_rst_status", {24'b0, st}, 32'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
